// File: rtl/som_pkg.sv
// som_pkg: shared types and sizes for the SOM weight-update stage.
package som_pkg;

    localparam int NUM_NEURON = 8;
    localparam int CH_W       = 8;
    localparam int W_W        = 24;
    localparam int IDX_W      = 3;
    localparam int SH_W       = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UPD_L = 3'd1,
        UPD_C = 3'd2,
        UPD_R = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/som_ch_update.sv
// som_ch_update: one 8-bit channel of w + ((x - w) >>> sh).
module som_ch_update
    import som_pkg::*;
(
    input  logic [CH_W-1:0] w,
    input  logic [CH_W-1:0] x,
    input  logic [SH_W-1:0] sh,
    output logic [CH_W-1:0] w_new
);

    logic signed [CH_W:0] diff;
    logic signed [CH_W:0] step;
    logic signed [CH_W:0] sum;

    assign diff = $signed({1'b0, x}) - $signed({1'b0, w});
    assign step = diff >>> sh;
    // The result stays between w and x, so the low bits are exact.
    assign sum   = $signed({1'b0, w}) + step;
    assign w_new = sum[CH_W-1:0];

endmodule

// File: rtl/som_update.sv
// som_update: moves the winner and its neighbours toward the
// training pixel, one neuron per cycle, through a shared write port.
module som_update
    import som_pkg::*;
#(
    parameter int SH_WIN = 1,
    parameter int SH_NB  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] win_index,
    input  logic [W_W-1:0]   pixel,
    input  logic             init_en,
    input  logic [IDX_W-1:0] init_index,
    input  logic [W_W-1:0]   init_w,
    output logic             busy,
    output logic             done,
    output logic [W_W-1:0]   w0,
    output logic [W_W-1:0]   w1,
    output logic [W_W-1:0]   w2,
    output logic [W_W-1:0]   w3,
    output logic [W_W-1:0]   w4,
    output logic [W_W-1:0]   w5,
    output logic [W_W-1:0]   w6,
    output logic [W_W-1:0]   w7
);

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W_W-1:0]   pix_q;
    logic [W_W-1:0]   w_q [NUM_NEURON];

    logic             accept;
    logic [IDX_W-1:0] upd_idx;
    logic [SH_W-1:0]  sh;
    logic [W_W-1:0]   upd_src;
    logic [W_W-1:0]   upd_w;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [W_W-1:0]   wr_data;

    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = (win_index == '0) ? UPD_C : UPD_L;
            end
            UPD_L: state_d = UPD_C;
            UPD_C: state_d = (idx_q == IDX_W'(NUM_NEURON - 1)) ? DONE : UPD_R;
            UPD_R: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upd_idx = idx_q;
        sh      = SH_W'(SH_WIN);
        case (state_q)
            UPD_L: begin
                upd_idx = idx_q - IDX_W'(1);
                sh      = SH_W'(SH_NB);
            end
            UPD_R: begin
                upd_idx = idx_q + IDX_W'(1);
                sh      = SH_W'(SH_NB);
            end
            default: ;
        endcase
    end

    assign upd_src = w_q[upd_idx];

    for (genvar c = 0; c < 3; c++) begin : g_ch
        som_ch_update u_ch (
            .w     (upd_src[c*CH_W +: CH_W]),
            .x     (pix_q[c*CH_W +: CH_W]),
            .sh    (sh),
            .w_new (upd_w[c*CH_W +: CH_W])
        );
    end

    // Start wins over a same-cycle preload; preloads only land in IDLE.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_w;
        unique case (1'b1)
            (state_q == UPD_L) || (state_q == UPD_C) || (state_q == UPD_R): begin
                wr_en = 1'b1;
            end
            (state_q == IDLE) && init_en && !start: begin
                wr_en   = 1'b1;
                wr_idx  = init_index;
                wr_data = init_w;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pix_q   <= '0;
            for (int i = 0; i < NUM_NEURON; i++)
                w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q <= win_index;
                pix_q <= pixel;
            end
            if (wr_en)
                w_q[wr_idx] <= wr_data;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    assign w0 = w_q[0];
    assign w1 = w_q[1];
    assign w2 = w_q[2];
    assign w3 = w_q[3];
    assign w4 = w_q[4];
    assign w5 = w_q[5];
    assign w6 = w_q[6];
    assign w7 = w_q[7];

endmodule

// File: doc/som_update.md
SOM_UPDATE -- requirements
Module: som_update

Interface
REQ-001 SHALL have parameter SH_WIN, default 1, which is the learning-rate shift for the winner neuron (alpha = 1/2^SH_WIN).
REQ-002 SHALL have parameter SH_NB, default 2, which is the learning-rate shift for the adjacent neurons.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: requests one update pass; sampled only in IDLE.
REQ-006 SHALL have port win_index, input, 3 bits: winning neuron index from the minimum-search stage; latched when start is accepted.
REQ-007 SHALL have port pixel, input, 24 bits: training vector {R,G,B}, 8 bits per channel; latched when start is accepted.
REQ-008 SHALL have port init_en, input, 1 bit: weight preload strobe.
REQ-009 SHALL have port init_index, input, 3 bits: index of the neuron to preload.
REQ-010 SHALL have port init_w, input, 24 bits: preload value.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.
REQ-013 SHALL have ports w0..w7, output, 24 bits each: registered weight of each neuron, driving the distance and minimum-search stages.

Function
REQ-014 SHALL implement the FSM states IDLE, UPD_L, UPD_C, UPD_R and DONE, spending exactly one cycle in each state it visits.
REQ-015 SHALL, when start is high in IDLE, latch win_index and pixel and go to UPD_L, or to UPD_C if win_index is 0.
REQ-016 SHALL go from UPD_L to UPD_C, and from UPD_C to UPD_R, or to DONE if the latched index is 7; UPD_R goes to DONE, and DONE goes to IDLE.
REQ-017 SHALL update neuron idx-1 in UPD_L and idx+1 in UPD_R using shift SH_NB, and neuron idx in UPD_C using shift SH_WIN. The neurons form a linear array with no wrap-around.
REQ-018 SHALL compute each 8-bit channel as w_new = w + ((x - w) >>> sh), using a 9-bit signed difference and an arithmetic (floor) shift. The result always lies in [min(w,x), max(w,x)], so no saturation is needed.
REQ-019 SHALL write the updated weight at the end of its state cycle, visible on wN in the following cycle.
REQ-020 SHALL give these timings, with the start cycle as cycle 0. For idx 1..6: updates in cycles 1, 2 and 3, done high in cycle 4. For idx 0 or 7: two updates, done high in cycle 3.
REQ-021 SHALL make init_en in IDLE write init_w into neuron init_index, visible in the next cycle.
REQ-022 SHALL ignore init_en and start while busy.
REQ-023 SHALL give start priority over init_en when both are high in IDLE; the init write is dropped.
REQ-024 SHALL let the pixel and win_index inputs change freely during a pass without effect, because the latched copies are used.
REQ-025 SHALL accept a new start in the cycle after DONE.

Reset
REQ-026 SHALL, when rst is high at a clock edge, set the state to IDLE, busy to 0, done to 0, w0..w7 to 24'h000000, and the latched index and pixel to 0.
REQ-027 SHALL abort any pass in progress on reset, with no done pulse.
REQ-028 SHALL give rst priority over start and init_en in the same cycle.

Structure
REQ-029 SHALL place the FSM state encoding, NUM_NEURON=8, CH_W=8, W_W=24 and IDX_W=3 in a shared package, som_pkg.
REQ-030 SHALL use one sub-module, som_ch_update: a combinational single-channel w/x/sh to w_new block, instantiated three times, with the shift selected by state.
REQ-031 SHALL hold the weight store as eight 24-bit registers with one shared write port.

Verification
REQ-032 SHALL cover reset: assert rst -> w0..w7=0, busy=0, done=0 in the next cycle.
REQ-033 SHALL cover a middle winner: preload w3=404040, w2=w4=000000, start idx=3, pixel=808080 -> w2=202020, w3=606060, w4=202020; done high only in cycle 4; other neurons unchanged.
REQ-034 SHALL cover the edge winner: all weights 101010, start idx=0, pixel=303030 -> w0=202020, w1=181818; done in cycle 3; w7 unchanged.
REQ-035 SHALL cover a negative difference: w5=01FF80, w4=w6=000000, idx=5, pixel=000000 -> w5=007F40.
REQ-036 SHALL cover the busy guard: start and init_en pulsed in cycle 2 of a pass -> ignored; a single done pulse; weights match a clean run.
REQ-037 SHALL cover reset mid-pass: rst in cycle 2 -> all weights 0, busy=0, no done pulse.
